seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the multi-digit seven-segment display. It owns the single shared hex-to-segment decoder. It presents one digit nibble at a time to the decoder and registers the returned pattern onto the common segment bus. It drives one-hot digit enables with a blanking gap between digits to prevent ghosting. New display values arrive through a shadow register and are applied only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
NUM_DIGITS, 4, number of digits scanned; digit 0 is the least significant.
DWELL_CYCLES, 1000, clock cycles each digit is lit (>=1).
BLANK_CYCLES, 16, clock cycles all digits are off before each digit is lit (>=1).

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
enable  in  1  scan enable; low forces display dark
value_in  in  4*NUM_DIGITS  packed nibbles; [3:0] is digit 0
load  in  1  one-cycle strobe; capture value_in into shadow register
lzb_en  in  1  leading-zero blanking enable
dec_hex  out  4  nibble to shared decoder (combinational from display reg and index)
dec_seg  in  7  decoder result {a..g}, active-high
seg_out  out  7  registered segment bus, active-high
digit_en  out  NUM_DIGITS  registered one-hot digit enable, active-high
frame_start  out  1  registered one-cycle pulse when a frame begins

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; idx=0; cnt=0.
  - display reg=0; shadow=0; pending=0.
  - seg_out=0; digit_en=0; frame_start=0.
  - Reset applies even mid-operation.
- Registers: display reg (active value), shadow reg, pending flag, idx (digit index), cnt (counter wide enough for max(DWELL_CYCLES,BLANK_CYCLES)-1).
- Load rule:
  - load=1 sets shadow<=value_in and pending<=1.
  - Multiple loads within one frame: the last one wins.
- Frame boundary event (FB):
  - Occurs on the IDLE->BLANK transition, or on the SHOW->BLANK transition when idx wraps NUM_DIGITS-1 -> 0.
  - At FB, display reg takes the new value:
    - if load=1 in the same cycle: display<=value_in directly, pending<=0;
    - else if pending=1: display<=shadow, pending<=0;
    - else display is unchanged.
  - frame_start<=1 for exactly one cycle, i.e. high during the first BLANK cycle of digit 0.
- dec_hex = display[4*idx+3 : 4*idx] at all times.
- State IDLE:
  - seg_out=0, digit_en=0.
  - If enable=1: go to BLANK with idx=0, cnt=0, and perform FB.
- State BLANK:
  - digit_en=0, seg_out=0.
  - cnt counts 0..BLANK_CYCLES-1.
  - On the edge where cnt==BLANK_CYCLES-1: go to SHOW, cnt<=0, digit_en<=onehot(idx), seg_out<=(blank(idx) ? 0 : dec_seg).
- State SHOW:
  - Outputs are held for exactly DWELL_CYCLES cycles.
  - On the edge where cnt==DWELL_CYCLES-1: go to BLANK, cnt<=0, digit_en<=0, seg_out<=0, idx<=(idx==NUM_DIGITS-1) ? 0 : idx+1.
  - On wrap, perform FB.
- Per-digit period = BLANK_CYCLES+DWELL_CYCLES.
- Frame period = NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES).
- Leading-zero blanking, blank(k):
  - True when lzb_en=1, k>0, and every nibble from NUM_DIGITS-1 down to k is 0.
  - Digit 0 is never blanked.
  - A blanked digit still gets its digit_en slot, but with seg_out=0.
  - lzb_en is sampled at the BLANK->SHOW edge.
- enable=0 in BLANK or SHOW:
  - The next edge goes to IDLE with idx=0, cnt=0, digit_en=0, seg_out=0, frame_start=0.
  - Shadow and pending are retained.
- enable has lower priority than rst; load is honoured in every state, including IDLE.
- digit_en is never multi-hot. seg_out is nonzero only while digit_en is nonzero.

Test Plan:
Use NUM_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=2, with a real seven_seg decoder on dec_hex/dec_seg.
1. rst, load value_in=16'h1234 in IDLE, then enable=1:
   - frame_start pulses 1 cycle; 2 dark cycles;
   - digit_en=0001, seg_out=0110011 ("4") for 4 cycles; 2 dark;
   - 0010 with 1111001 ("3"), then 0100 with 1101101, then 1000 with 0110000;
   - frame repeats every 24 cycles.
2. Load 16'hABCD while digit 1 is lit:
   - digits 2,3 of the current frame still show "2","1";
   - next frame, digit 0 shows 0111101 ("d") and digit 3 shows 1110111 ("A").
3. lzb_en=1, value 16'h0050:
   - digits 3 and 2 get enable slots with seg_out=0;
   - digit 1 shows 1011011; digit 0 shows 1111110.
   - With value 16'h0000, only digit 0 is lit ("0").
4. load asserted on the exact wrap edge (last SHOW cycle of digit 3):
   - the new value is shown from digit 0 of the next frame;
   - pending=0 afterwards, so there is no second update at the following FB.
5. enable dropped mid-SHOW of digit 2:
   - next cycle digit_en=0, seg_out=0;
   - re-enable restarts at digit 0 with a frame_start pulse and applies any pending load.
6. rst asserted mid-SHOW:
   - next cycle all outputs are 0 and display=0;
   - after enable, all digits show "0" (or only digit 0 if lzb_en=1).

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: walks the digits through a shared
// hex decoder, with blanking gaps and frame-synchronous display updates.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    input  logic                    lzb_en,
    output logic [3:0]              dec_hex,
    input  logic [6:0]              dec_seg,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_start
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES ? DWELL_CYCLES : BLANK_CYCLES) - 1;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W   = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t                state, state_nx;
    logic [IDX_W-1:0]      idx, idx_nx;
    logic [CNT_W-1:0]      cnt, cnt_nx;
    logic [VAL_W-1:0]      display, display_nx;
    logic [VAL_W-1:0]      shadow, shadow_nx;
    logic                  pending, pending_nx;
    logic [6:0]            seg_out_nx;
    logic [NUM_DIGITS-1:0] digit_en_nx;
    logic                  frame_start_nx;
    logic                  fb;
    logic                  blank_dig;

    assign dec_hex = display[{idx, 2'b00} +: 4];

    // Current digit is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        blank_dig = lzb_en && (idx != '0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(idx) && display[4*k +: 4] != 4'h0) blank_dig = 1'b0;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx       = state;
        idx_nx         = idx;
        cnt_nx         = cnt;
        display_nx     = display;
        shadow_nx      = shadow;
        pending_nx     = pending;
        seg_out_nx     = seg_out;
        digit_en_nx    = digit_en;
        frame_start_nx = 1'b0;
        fb             = 1'b0;

        if (load) begin
            shadow_nx  = value_in;
            pending_nx = 1'b1;
        end

        case (state)
            IDLE: begin
                seg_out_nx  = '0;
                digit_en_nx = '0;
                if (enable) begin
                    state_nx = BLANK;
                    idx_nx   = '0;
                    cnt_nx   = '0;
                    fb       = 1'b1;
                end
            end
            BLANK, SHOW: begin
                if (!enable) begin
                    state_nx    = IDLE;
                    idx_nx      = '0;
                    cnt_nx      = '0;
                    seg_out_nx  = '0;
                    digit_en_nx = '0;
                end else if (state == BLANK && cnt == BLANK_LAST) begin
                    state_nx    = SHOW;
                    cnt_nx      = '0;
                    digit_en_nx = NUM_DIGITS'(1) << idx;
                    seg_out_nx  = blank_dig ? 7'd0 : dec_seg;
                end else if (state == SHOW && cnt == DWELL_LAST) begin
                    state_nx    = BLANK;
                    cnt_nx      = '0;
                    seg_out_nx  = '0;
                    digit_en_nx = '0;
                    if (idx == IDX_LAST) begin
                        idx_nx = '0;
                        fb     = 1'b1;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // A load coinciding with the frame boundary bypasses the shadow register.
        if (fb) begin
            frame_start_nx = 1'b1;
            if (load) begin
                display_nx = value_in;
                pending_nx = 1'b0;
            end else if (pending) begin
                display_nx = shadow;
                pending_nx = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            display     <= '0;
            shadow      <= '0;
            pending     <= 1'b0;
            seg_out     <= '0;
            digit_en    <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            cnt         <= cnt_nx;
            display     <= display_nx;
            shadow      <= shadow_nx;
            pending     <= pending_nx;
            seg_out     <= seg_out_nx;
            digit_en    <= digit_en_nx;
            frame_start <= frame_start_nx;
        end
    end

endmodule
